// File: rtl/fft_result_sink_if.sv
// Stream bundle between the FFT core output, the result sink, and the downstream consumer.
// The slave view belongs to the sink; the master view belongs to the FFT core and the consumer side.
interface fft_result_sink_if #(
    parameter int FFT_SIZE   = 16,
    parameter int DATA_WIDTH = 16
) ();
    logic                          fft_out_valid;
    logic [2*DATA_WIDTH-1:0]       fft_out_data;
    logic                          fft_out_ready;
    logic                          bin_valid;
    logic [$clog2(FFT_SIZE)-1:0]   bin_idx;
    logic [2*DATA_WIDTH:0]         bin_mag;
    logic                          bin_ready;

    modport master (
        output fft_out_valid, fft_out_data, bin_ready,
        input  fft_out_ready, bin_valid, bin_idx, bin_mag
    );

    modport slave (
        input  fft_out_valid, fft_out_data, bin_ready,
        output fft_out_ready, bin_valid, bin_idx, bin_mag
    );
endinterface

// File: rtl/fft_result_sink.sv
// FFT output sink: collects one frame, streams |X|^2 per bin, and tracks the frame's peak bin.
// Optional collect-phase watchdog: define FFT_RESULT_SINK_TIMEOUT_EN (adds TIMEOUT_CYCLES and timeout_o).
module fft_result_sink #(
    parameter int FFT_SIZE   = 16,
    parameter int DATA_WIDTH = 16,
    parameter bit SKIP_DC    = 1'b1
`ifdef FFT_RESULT_SINK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    output logic                          read_ram_o,
    fft_result_sink_if.slave              bus,
    output logic [$clog2(FFT_SIZE)-1:0]   peak_idx_o,
    output logic [2*DATA_WIDTH:0]         peak_mag_o,
    output logic                          frame_done_o,
    output logic                          busy_o
`ifdef FFT_RESULT_SINK_TIMEOUT_EN
    ,
    output logic                          timeout_o
`endif
);
    localparam int IW = $clog2(FFT_SIZE);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int MW = 2 * DATA_WIDTH + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   in_cnt_q, in_cnt_d;
    logic            bin_valid_q, bin_valid_d;
    logic [IW-1:0]   bin_idx_q, bin_idx_d;
    logic [MW-1:0]   bin_mag_q, bin_mag_d;
    logic [MW-1:0]   run_mag_q, run_mag_d;
    logic [IW-1:0]   run_idx_q, run_idx_d;
    logic [MW-1:0]   peak_mag_q, peak_mag_d;
    logic [IW-1:0]   peak_idx_q, peak_idx_d;

    logic            ready_s;
    logic            accept_s;
    logic            drain_done_s;
    logic            skip_s;
    logic            to_fire_s;
    logic [MW-1:0]   mag_s;

    // Squares are taken on sign-extended operands; even (-2^(DW-1))^2 stays positive in PW bits.
    function automatic logic [MW-1:0] mag_sq(input logic [PW-1:0] d);
        logic signed [PW-1:0] re_x;
        logic signed [PW-1:0] im_x;
        logic signed [PW-1:0] re_sq;
        logic signed [PW-1:0] im_sq;
        re_x  = {{DATA_WIDTH{d[PW-1]}}, d[PW-1:DATA_WIDTH]};
        im_x  = {{DATA_WIDTH{d[DATA_WIDTH-1]}}, d[DATA_WIDTH-1:0]};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        return {1'b0, re_sq} + {1'b0, im_sq};
    endfunction

    assign ready_s      = (state_q == S_COLLECT) && (!bin_valid_q || bus.bin_ready);
    assign accept_s     = ready_s && bus.fft_out_valid;
    assign drain_done_s = (state_q == S_DRAIN) && bin_valid_q && bus.bin_ready;
    assign skip_s       = SKIP_DC && (in_cnt_q == {IW{1'b0}});
    assign mag_s        = mag_sq(bus.fft_out_data);

`ifdef FFT_RESULT_SINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q;

    assign to_fire_s = (state_q == S_COLLECT) && !accept_s && (to_cnt_q == TO_LAST);

    // Idle-cycle counter, only running while waiting for input bins.
    always_comb begin
        to_cnt_d = {TW{1'b0}};
        if ((state_q == S_COLLECT) && !accept_s && !to_fire_s) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = {TW{1'b0}};
        end
    end

    // Watchdog counter and its one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q  <= {TW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= to_fire_s;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_fire_s = 1'b0;
`endif

    // Frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_COLLECT;
                else         state_d = S_IDLE;
            end
            S_COLLECT: begin
                if (to_fire_s)                               state_d = S_IDLE;
                else if (accept_s && (in_cnt_q == LAST_IDX)) state_d = S_DRAIN;
                else                                         state_d = S_COLLECT;
            end
            S_DRAIN: begin
                if (drain_done_s) state_d = S_DONE;
                else              state_d = S_DRAIN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bin counter, output register and peak tracking.
    always_comb begin
        in_cnt_d    = in_cnt_q;
        bin_valid_d = bin_valid_q;
        bin_idx_d   = bin_idx_q;
        bin_mag_d   = bin_mag_q;
        run_mag_d   = run_mag_q;
        run_idx_d   = run_idx_q;
        peak_mag_d  = peak_mag_q;
        peak_idx_d  = peak_idx_q;

        if ((state_q == S_IDLE) && start_i) begin
            in_cnt_d  = {IW{1'b0}};
            run_mag_d = {MW{1'b0}};
            run_idx_d = {IW{1'b0}};
        end else if (accept_s) begin
            in_cnt_d = in_cnt_q + IW'(1);
        end else begin
            in_cnt_d = in_cnt_q;
        end

        // A reload on the same edge as a consume keeps valid high.
        if (accept_s) begin
            bin_valid_d = 1'b1;
            bin_idx_d   = in_cnt_q;
            bin_mag_d   = mag_s;
        end else if (bus.bin_ready || to_fire_s) begin
            bin_valid_d = 1'b0;
        end else begin
            bin_valid_d = bin_valid_q;
        end

        // Strict compare keeps the lowest index on ties.
        if (accept_s && !skip_s && (mag_s > run_mag_q)) begin
            run_mag_d = mag_s;
            run_idx_d = in_cnt_q;
        end else begin
            run_mag_d = run_mag_d;
        end

        if (drain_done_s) begin
            peak_mag_d = run_mag_q;
            peak_idx_d = run_idx_q;
        end else begin
            peak_mag_d = peak_mag_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= {IW{1'b0}};
            bin_valid_q <= 1'b0;
            bin_idx_q   <= {IW{1'b0}};
            bin_mag_q   <= {MW{1'b0}};
            run_mag_q   <= {MW{1'b0}};
            run_idx_q   <= {IW{1'b0}};
            peak_mag_q  <= {MW{1'b0}};
            peak_idx_q  <= {IW{1'b0}};
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            bin_valid_q <= bin_valid_d;
            bin_idx_q   <= bin_idx_d;
            bin_mag_q   <= bin_mag_d;
            run_mag_q   <= run_mag_d;
            run_idx_q   <= run_idx_d;
            peak_mag_q  <= peak_mag_d;
            peak_idx_q  <= peak_idx_d;
        end
    end

    assign read_ram_o        = (state_q == S_COLLECT);
    assign busy_o            = (state_q != S_IDLE);
    assign frame_done_o      = (state_q == S_DONE);
    assign bus.fft_out_ready = ready_s;
    assign bus.bin_valid     = bin_valid_q;
    assign bus.bin_idx       = bin_idx_q;
    assign bus.bin_mag       = bin_mag_q;
    assign peak_idx_o        = peak_idx_q;
    assign peak_mag_o        = peak_mag_q;

endmodule

// File: doc/fft_result_sink.md
Name: fft_result_sink

Overview:
- Consumer end of the FFT core's complex output stream.
- Requests a frame via read_ram_o, accepts FFT_SIZE complex bins over valid/ready, and computes |X|^2 per bin.
- Streams (index, magnitude) pairs downstream and tracks the peak bin of the frame.
- Sits between the FFT core output and the spectrum CSR/DMA logic.

Parameters:
- FFT_SIZE, 16, bins per frame; power of 2, >= 4.
- DATA_WIDTH, 16, width of each signed re/im component.
- SKIP_DC, 1, when 1, bin 0 is excluded from peak search; it is still streamed.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  pulse: request one frame; ignored unless IDLE
- read_ram_o  output  1  held high in COLLECT; drives FFT core read_ram_i
- fft_out_valid_i  input  1  input bin valid
- fft_out_data_i  input  2*DATA_WIDTH  {re[2DW-1:DW], im[DW-1:0]}, signed
- fft_out_ready_o  output  1  input bin accepted when valid && ready
- bin_valid_o  output  1  output magnitude valid
- bin_idx_o  output  $clog2(FFT_SIZE)  bin index of bin_mag_o
- bin_mag_o  output  2*DATA_WIDTH+1  re^2+im^2, unsigned
- bin_ready_i  input  1  downstream ready
- peak_idx_o  output  $clog2(FFT_SIZE)  index of max magnitude, last completed frame
- peak_mag_o  output  2*DATA_WIDTH+1  max magnitude, last completed frame
- frame_done_o  output  1  one-cycle pulse when the last bin is accepted downstream
- busy_o  output  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Counters cleared. peak_idx_o and peak_mag_o are 0.
- States: IDLE -> COLLECT on start_i. COLLECT -> DRAIN when input bin FFT_SIZE-1 is accepted. DRAIN -> DONE when the output register empties (last bin accepted). DONE -> IDLE unconditionally after 1 cycle.
- start_i outside IDLE: ignored, no effect.
- read_ram_o = (state==COLLECT).
- fft_out_ready_o = (state==COLLECT) && (!bin_valid_o || bin_ready_i). This gives a single-register pipeline with full throughput and no combinational path from valid to ready.
- Input accepted (valid && ready):
  - In-counter increments, wrapping to 0 after FFT_SIZE-1.
  - Output register loads on the next edge: mag = re*re + im*im, computed as signed products at full width, sum zero-extended to 2DW+1. No saturation. Max is 2*(2^(DW-1))^2 = 2^(2DW-1); it fits.
  - bin_idx_o = in-counter value at acceptance.
  - Latency: accepted input -> bin_valid_o is 1 cycle.
- bin_valid_o clears when bin_ready_i && no new input is accepted that cycle. A simultaneous accept and consume reloads the register, and bin_valid_o stays high.
- Output held stable while bin_valid_o && !bin_ready_i (AXI-style rule).
- Peak tracking on each input acceptance, in the same cycle the magnitude is registered:
  - Running max updates only if mag > running max (strict). Ties keep the lowest index.
  - With SKIP_DC=1, index 0 never updates it.
  - Running max clears to 0 on IDLE->COLLECT, and its index clears to 0.
  - peak_idx_o/peak_mag_o update only at frame_done_o and hold until the next frame completes.
- frame_done_o: high for exactly one cycle, coinciding with DRAIN->DONE.
- Asynchronous reset mid-frame: everything returns to reset values and the partial frame is discarded. Stale FFT core output after reset is not accepted, because ready is low in IDLE.
- fft_out_valid_i outside COLLECT: not accepted. The FFT core holds its data.

Optional Feature:
- Macro: FFT_RESULT_SINK_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and output timeout_o (1 bit).
  - In COLLECT, a counter increments each cycle without an input handshake and clears on each handshake.
  - At TIMEOUT_CYCLES it pulses timeout_o for one cycle, FSM goes to IDLE, and read_ram_o drops.
  - No frame_done_o and no peak update occur. bin_valid_o is cleared.
- Without the macro: no port, no counter. COLLECT waits indefinitely.

Test Plan (DW=16, FFT_SIZE=8, SKIP_DC=1):
- Reset with random inputs -> all outputs 0. busy_o=0. fft_out_ready_o=0.
- start_i pulse, then 8 back-to-back bins with re=k*100, im=0, bin_ready_i=1 -> bin_mag_o = 0, 10000, 40000, … 490000, indices 0..7, each 1 cycle after acceptance. frame_done_o pulses once. peak_idx_o=7, peak_mag_o=490000.
- Bins all 0 except bin 0 = (0x7FFF, 0x7FFF) and bins 3, 5 = (0x4000, 0) -> peak_idx_o=3 (DC skipped, tie keeps lowest). peak_mag_o=0x10000000.
- Extreme bin (0x8000, 0x8000) -> bin_mag_o = 0x80000000 (2^31), no overflow in 33 bits.
- bin_ready_i toggles 1/0 every cycle -> fft_out_ready_o never high while the register is held. bin_mag_o stable while stalled. All 8 bins delivered in order, none lost or duplicated.
- Assert rst_ni low after 4 bins, release, send start_i plus a full frame -> indices restart at 0. Peak reflects only the new frame. start_i during COLLECT is ignored. With FFT_RESULT_SINK_TIMEOUT_EN and TIMEOUT_CYCLES=16, stop valid after 3 bins -> timeout_o pulses 16 cycles later, busy_o=0, no frame_done_o.
